// File: rtl/sq_operand_buffer_pkg.sv
// -----------------------------------------------------------------------------
// sq_operand_buffer_pkg
//   Shared calculator definitions for the operand buffer that sits between the
//   debounced switch inputs and the ALU/display path.
//
//   Contents:
//     SQ_WIDTH_DEFAULT  default entry width (ALU operand/result width)
//     SQ_DEPTH_DEFAULT  default entry count (power of two, >= 4)
//     SQ_MODE_STACK/QUEUE  encodings of the stack/queue switch
//     sq_state_e        pop sequencing FSM state encoding
// -----------------------------------------------------------------------------
package sq_operand_buffer_pkg;

    localparam int SQ_WIDTH_DEFAULT = 32;
    localparam int SQ_DEPTH_DEFAULT = 8;

    localparam logic SQ_MODE_STACK = 1'b0;
    localparam logic SQ_MODE_QUEUE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP1 = 2'd1,
        ST_POP2 = 2'd2,
        ST_DONE = 2'd3
    } sq_state_e;

endpackage : sq_operand_buffer_pkg

// File: rtl/sq_operand_buffer.sv
// -----------------------------------------------------------------------------
// sq_operand_buffer
//   Operand storage for the calculator. Holds up to DEPTH entries in a circular
//   array and hands two operands to the ALU per pop2_req, either in stack
//   (LIFO) or queue (FIFO) order selected by the debounced mode switch.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | accepts pushes (when not full) or a pop2_req (when count >= 2)
//   POP1  | removes first operand: stack -> B (newest), queue -> A (head)
//   POP2  | removes second operand: stack -> A, queue -> B
//   DONE  | pop_valid high for one cycle, pop_a/pop_b presented to the ALU
//
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous active-low reset
//     mode        0 = stack, 1 = queue (registered only while empty in IDLE)
//     push_valid  push request
//     push_data   value to push
//     push_ready  push accepted when push_valid && push_ready
//     pop2_req    request to remove two operands (one-cycle pulse)
//     pop_valid   one-cycle pulse, pop_a/pop_b valid
//     pop_a       ALU operand A (held until the next DONE)
//     pop_b       ALU operand B (held until the next DONE)
//     top         display value: newest (stack) / head (queue) / 0 if empty
//     count       occupancy, 0..DEPTH
//     empty/full  count == 0 / count == DEPTH
//     err         one-cycle pulse on overflow or underflow attempt
// -----------------------------------------------------------------------------
module sq_operand_buffer
    import sq_operand_buffer_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH_DEFAULT,
    parameter int DEPTH = SQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     push_valid,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     push_ready,
    input  logic                     pop2_req,
    output logic                     pop_valid,
    output logic [WIDTH-1:0]         pop_a,
    output logic [WIDTH-1:0]         pop_b,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sq_state_e          r_state;
    sq_state_e          w_state_nxt;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_mode;
    logic               r_err;
    logic [WIDTH-1:0]   r_pop_a;
    logic [WIDTH-1:0]   r_pop_b;

    logic [PW-1:0]      w_newest_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_err;
    logic               w_push_ready;
    logic [WIDTH-1:0]   w_top;

    // Occupancy is tracked only by r_count; pointers may be equal both when
    // empty and when full, so they are never compared.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_newest_ptr = r_wr_ptr - PW'(1);

    // ------------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_err        = 1'b0;
        w_push_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // pop2_req wins over a same-cycle push; the push is dropped,
                // so push_ready is withdrawn in that cycle as well.
                w_push_ready = !w_full && !pop2_req;
                if (pop2_req) begin
                    if (r_count >= CW'(2)) begin
                        w_state_nxt = ST_POP1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (push_valid) begin
                    if (w_full) begin
                        w_err = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            ST_POP1: w_state_nxt = ST_POP2;
            ST_POP2: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, pointers, occupancy, operand registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_mode   <= SQ_MODE_STACK;
            r_err    <= 1'b0;
            r_pop_a  <= '0;
            r_pop_b  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;

            // Order of stored entries depends on the mode they were pushed
            // under, so the switch is only honoured while nothing is stored.
            if (r_state == ST_IDLE && w_empty) begin
                r_mode <= mode;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_count  <= r_count + CW'(1);
            end

            if (r_state == ST_POP1 || r_state == ST_POP2) begin
                r_count <= r_count - CW'(1);
                if (r_mode == SQ_MODE_QUEUE) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                    if (r_state == ST_POP1) begin
                        r_pop_a <= r_mem[r_rd_ptr];
                    end else begin
                        r_pop_b <= r_mem[r_rd_ptr];
                    end
                end else begin
                    r_wr_ptr <= w_newest_ptr;
                    if (r_state == ST_POP1) begin
                        r_pop_b <= r_mem[w_newest_ptr];
                    end else begin
                        r_pop_a <= r_mem[w_newest_ptr];
                    end
                end
            end
        end
    end

    // Storage array: no reset, contents undefined after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Display value
    // ------------------------------------------------------------------------
    always_comb begin
        w_top = '0;
        if (!w_empty) begin
            if (r_mode == SQ_MODE_QUEUE) begin
                w_top = r_mem[r_rd_ptr];
            end else begin
                w_top = r_mem[w_newest_ptr];
            end
        end
    end

    assign push_ready = w_push_ready;
    assign pop_valid  = (r_state == ST_DONE);
    assign pop_a      = r_pop_a;
    assign pop_b      = r_pop_b;
    assign top        = w_top;
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign err        = r_err;

endmodule : sq_operand_buffer

// File: tb/tb_sq_operand_buffer.sv
// -----------------------------------------------------------------------------
// tb_sq_operand_buffer
//   Directed bench for sq_operand_buffer with WIDTH=32, DEPTH=8.
// -----------------------------------------------------------------------------
module tb_sq_operand_buffer;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        pop2_req;
    logic        pop_valid;
    logic [31:0] pop_a;
    logic [31:0] pop_b;
    logic [31:0] top;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        err;

    int n_cmp;
    int n_bad;

    sq_operand_buffer #(.WIDTH(32), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop2_req   (pop2_req),
        .pop_valid  (pop_valid),
        .pop_a      (pop_a),
        .pop_b      (pop_b),
        .top        (top),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic do_push(input logic [31:0] v);
        push_valid = 1'b1;
        push_data  = v;
        tick();
        push_valid = 1'b0;
    endtask

    // Issues pop2_req (optionally with a same-cycle push) and returns the number
    // of cycles until pop_valid is seen, bounded at 10. Returns in the DONE cycle.
    task automatic run_pop2(input logic with_push, input logic [31:0] v, output int lat);
        pop2_req   = 1'b1;
        push_valid = with_push;
        push_data  = v;
        tick();
        pop2_req   = 1'b0;
        push_valid = 1'b0;
        lat = 1;
        while (!pop_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++; if (count !== 4'd0)   begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL reset_full: got %0b want 0", full); end
        n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pop_valid: got %0b want 0", pop_valid); end
        n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
        n_cmp++; if (pop_a !== 32'd0)  begin n_bad++; $display("FAIL reset_pop_a: got %0h want 0", pop_a); end
        n_cmp++; if (pop_b !== 32'd0)  begin n_bad++; $display("FAIL reset_pop_b: got %0h want 0", pop_b); end
        n_cmp++; if (top !== 32'd0)    begin n_bad++; $display("FAIL reset_top: got %0h want 0", top); end
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready: got %0b want 1", push_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stack();
        int lat;
        apply_reset();
        mode = 1'b0;
        do_push(32'd5);
        do_push(32'd3);
        n_cmp++; if (count !== 4'd2)  begin n_bad++; $display("FAIL stack_count2: got %0d want 2", count); end
        n_cmp++; if (top !== 32'd3)   begin n_bad++; $display("FAIL stack_top: got %0d want 3", top); end
        run_pop2(1'b0, 32'd0, lat);
        n_cmp++; if (lat !== 3)       begin n_bad++; $display("FAIL stack_latency: got %0d want 3", lat); end
        n_cmp++; if (pop_a !== 32'd5) begin n_bad++; $display("FAIL stack_pop_a: got %0d want 5", pop_a); end
        n_cmp++; if (pop_b !== 32'd3) begin n_bad++; $display("FAIL stack_pop_b: got %0d want 3", pop_b); end
        n_cmp++; if (count !== 4'd0)  begin n_bad++; $display("FAIL stack_count0: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL stack_empty: got %0b want 1", empty); end
        tick();
        n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL stack_pulse_end: got %0b want 0", pop_valid); end
        n_cmp++; if (pop_a !== 32'd5) begin n_bad++; $display("FAIL stack_hold_a: got %0d want 5", pop_a); end
        n_cmp++; if (top !== 32'd0)   begin n_bad++; $display("FAIL stack_top_empty: got %0d want 0", top); end
    endtask

    task automatic test_queue_and_underflow();
        int lat;
        int seen;
        apply_reset();
        mode = 1'b1;
        do_push(32'd7);
        do_push(32'd2);
        do_push(32'd9);
        n_cmp++; if (top !== 32'd7)   begin n_bad++; $display("FAIL queue_top_head: got %0d want 7", top); end
        run_pop2(1'b0, 32'd0, lat);
        n_cmp++; if (lat !== 3)       begin n_bad++; $display("FAIL queue_latency: got %0d want 3", lat); end
        n_cmp++; if (pop_a !== 32'd7) begin n_bad++; $display("FAIL queue_pop_a: got %0d want 7", pop_a); end
        n_cmp++; if (pop_b !== 32'd2) begin n_bad++; $display("FAIL queue_pop_b: got %0d want 2", pop_b); end
        n_cmp++; if (count !== 4'd1)  begin n_bad++; $display("FAIL queue_count: got %0d want 1", count); end
        n_cmp++; if (top !== 32'd9)   begin n_bad++; $display("FAIL queue_top_after: got %0d want 9", top); end
        tick();
        // underflow: one entry left
        pop2_req = 1'b1;
        tick();
        pop2_req = 1'b0;
        n_cmp++; if (err !== 1'b1)    begin n_bad++; $display("FAIL under_err: got %0b want 1", err); end
        n_cmp++; if (count !== 4'd1)  begin n_bad++; $display("FAIL under_count: got %0d want 1", count); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pop_valid) seen++;
            if (i == 0) begin
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL under_err_pulse: got %0b want 0", err); end
            end
        end
        n_cmp++; if (seen !== 0)      begin n_bad++; $display("FAIL under_no_pop: got %0d want 0", seen); end
        n_cmp++; if (top !== 32'd9)   begin n_bad++; $display("FAIL under_top: got %0d want 9", top); end
    endtask

    task automatic test_full_wrap();
        int lat;
        logic [31:0] exp_a [4];
        logic [31:0] exp_b [4];
        exp_a[0] = 32'h12; exp_b[0] = 32'h13;
        exp_a[1] = 32'h14; exp_b[1] = 32'h15;
        exp_a[2] = 32'h16; exp_b[2] = 32'h17;
        exp_a[3] = 32'h20; exp_b[3] = 32'h21;
        apply_reset();
        mode = 1'b1;
        for (int i = 0; i < 8; i++) do_push(32'h10 + 32'(i));
        n_cmp++; if (full !== 1'b1)   begin n_bad++; $display("FAIL full_flag: got %0b want 1", full); end
        n_cmp++; if (count !== 4'd8)  begin n_bad++; $display("FAIL full_count: got %0d want 8", count); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b want 0", push_ready); end
        do_push(32'h99);
        n_cmp++; if (err !== 1'b1)    begin n_bad++; $display("FAIL over_err: got %0b want 1", err); end
        n_cmp++; if (count !== 4'd8)  begin n_bad++; $display("FAIL over_count: got %0d want 8", count); end
        n_cmp++; if (top !== 32'h10)  begin n_bad++; $display("FAIL over_top: got %0h want 10", top); end
        tick();
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL over_err_pulse: got %0b want 0", err); end
        run_pop2(1'b0, 32'd0, lat);
        n_cmp++; if (pop_a !== 32'h10 || pop_b !== 32'h11) begin n_bad++; $display("FAIL full_pop0: got %0h/%0h want 10/11", pop_a, pop_b); end
        n_cmp++; if (count !== 4'd6)  begin n_bad++; $display("FAIL full_count6: got %0d want 6", count); end
        tick();
        do_push(32'h20);
        do_push(32'h21);
        n_cmp++; if (full !== 1'b1)   begin n_bad++; $display("FAIL wrap_full: got %0b want 1", full); end
        for (int k = 0; k < 4; k++) begin
            run_pop2(1'b0, 32'd0, lat);
            n_cmp++;
            if (lat !== 3 || pop_a !== exp_a[k] || pop_b !== exp_b[k]) begin
                n_bad++;
                $display("FAIL wrap_pop%0d: got lat %0d a %0h b %0h want lat 3 a %0h b %0h", k, lat, pop_a, pop_b, exp_a[k], exp_b[k]);
            end
            tick();
        end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL wrap_empty: got %0b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        int lat;
        apply_reset();
        mode = 1'b0;
        do_push(32'd1);
        do_push(32'd2);
        run_pop2(1'b1, 32'd77, lat);
        n_cmp++; if (lat !== 3)       begin n_bad++; $display("FAIL simul_latency: got %0d want 3", lat); end
        n_cmp++; if (pop_a !== 32'd1 || pop_b !== 32'd2) begin n_bad++; $display("FAIL simul_ops: got %0d/%0d want 1/2", pop_a, pop_b); end
        tick();
        n_cmp++; if (count !== 4'd0)  begin n_bad++; $display("FAIL simul_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL simul_empty: got %0b want 1", empty); end
    endtask

    task automatic test_reset_mid_pop();
        int seen;
        apply_reset();
        mode = 1'b0;
        do_push(32'd4);
        do_push(32'd6);
        pop2_req = 1'b1;
        tick();
        pop2_req = 1'b0;
        rst = 1'b0;
        #2;
        n_cmp++; if (count !== 4'd0)  begin n_bad++; $display("FAIL midpop_count: got %0d want 0", count); end
        n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL midpop_valid: got %0b want 0", pop_valid); end
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pop_valid) seen++;
        end
        n_cmp++; if (seen !== 0)      begin n_bad++; $display("FAIL midpop_no_pulse: got %0d want 0", seen); end
        n_cmp++; if (empty !== 1'b1)  begin n_bad++; $display("FAIL midpop_empty: got %0b want 1", empty); end
    endtask

    task automatic test_mode_toggle();
        int lat;
        apply_reset();
        mode = 1'b1;
        do_push(32'd7);
        mode = 1'b0;
        do_push(32'd8);
        do_push(32'd9);
        n_cmp++; if (top !== 32'd7)   begin n_bad++; $display("FAIL toggle_top: got %0d want 7", top); end
        run_pop2(1'b0, 32'd0, lat);
        n_cmp++; if (pop_a !== 32'd7 || pop_b !== 32'd8) begin n_bad++; $display("FAIL toggle_ops: got %0d/%0d want 7/8", pop_a, pop_b); end
        n_cmp++; if (count !== 4'd1)  begin n_bad++; $display("FAIL toggle_count: got %0d want 1", count); end
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        mode       = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop2_req   = 1'b0;
        #2;
        test_reset();
        test_stack();
        test_queue_and_underflow();
        test_full_wrap();
        test_simultaneous();
        test_reset_mid_pop();
        test_mode_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sq_operand_buffer

// File: doc/sq_operand_buffer.md
SQ_OPERAND_BUFFER -- requirements
Module: sq_operand_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: entry width in bits; matches the ALU operand/result width.
REQ-002 SHALL have parameter DEPTH, default 8: entry count; a power of two, at least 4.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 1: 0 = stack (LIFO), 1 = queue (FIFO); driven by the debounced stack/queue switch.
REQ-006 SHALL have port push_valid, input, 1: push request.
REQ-007 SHALL have port push_data, input, WIDTH: data to push; switches zero-extended, or the ALU result.
REQ-008 SHALL have port push_ready, output, 1: a push is accepted this cycle when both push_valid and push_ready are high.
REQ-009 SHALL have port pop2_req, input, 1: request to remove two operands; one-cycle pulse.
REQ-010 SHALL have port pop_valid, output, 1: one-cycle pulse; pop_a and pop_b are valid in that cycle.
REQ-011 SHALL have ports pop_a and pop_b, output, WIDTH: ALU operands A and B.
REQ-012 SHALL have port top, output, WIDTH: value for the seven-segment display.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have ports empty and full, output, 1 each: empty = (count==0); full = (count==DEPTH).
REQ-015 SHALL have port err, output, 1: one-cycle pulse on an overflow or underflow attempt.

Function
REQ-016 SHALL store entries in a circular array with rd_ptr and wr_ptr; each pointer wraps from DEPTH-1 to 0.
REQ-017 SHALL use an FSM with states IDLE -> POP1 -> POP2 -> DONE -> IDLE; pop2_req is accepted only in IDLE.
REQ-018 SHALL hold push_ready = 1 only in IDLE when !full; a push writes push_data at the insertion point, advances wr_ptr and increments count one cycle later.
REQ-019 SHALL, in stack mode, take B from the newest entry (POP1) and A from the next-newest entry (POP2), decrementing wr_ptr and count once in each state.
REQ-020 SHALL, in queue mode, take A from the head entry (POP1) and B from head+1 (POP2), incrementing rd_ptr and decrementing count once in each state.
REQ-021 SHALL assert pop_valid in DONE, i.e. exactly 3 cycles after the accepted pop2_req edge; pop_a and pop_b SHALL hold their values until the next DONE.
REQ-022 SHALL, when pop2_req arrives in IDLE with count<2, leave the FSM in IDLE, change no state, and pulse err.
REQ-023 SHALL, when push_valid arrives while full, drop the data, leave count unchanged, and pulse err.
REQ-024 SHALL give pop2_req priority when pop2_req and push_valid are asserted in the same IDLE cycle; the push is not accepted and is not queued.
REQ-025 SHALL register mode only while empty and in IDLE; while non-empty, the registered mode SHALL be held and input changes ignored.
REQ-026 SHALL drive top as follows: stack mode = newest entry; queue mode = head entry; 0 when empty. top is combinational from the array and pointers.
REQ-027 SHALL keep count within 0..DEPTH; simultaneous pointer wrap and full/empty transitions are handled by count, never by pointer compare.

Reset
REQ-028 SHALL, on rst low, asynchronously force: FSM=IDLE, rd_ptr=wr_ptr=0, count=0, registered mode=0, pop_a=pop_b=0, pop_valid=0, err=0.
REQ-029 SHALL abort any in-flight pop when rst is asserted mid-pop; no pop_valid pulse follows reset.
REQ-030 SHALL leave array contents undefined after reset; they are not reset.

Structure
REQ-031 SHALL place the FSM state encoding and the DEPTH/WIDTH defaults in a shared calculator package.
REQ-032 SHALL be implemented as a single module; the array is inferred RAM or registers, with no sub-module.
REQ-033 SHALL be instantiated between the debouncers and the ALU/display path in place of the storage inside the memory controller.

Verification
REQ-034 SHALL cover stack mode: push 5, push 3, pop2_req -> pop_valid 3 cycles later, pop_a=5, pop_b=3, count=0, empty=1.
REQ-035 SHALL cover queue mode: push 7, 2, 9, then pop2_req -> pop_a=7, pop_b=2, count=1, top=9.
REQ-036 SHALL cover full with DEPTH=8: 8 pushes -> full=1; 9th push -> err pulse, count=8; then pop2 in queue mode and 2 pushes exercise wrap, entries read back in order.
REQ-037 SHALL cover underflow: 1 entry, pop2_req -> err pulse, count=1, no pop_valid.
REQ-038 SHALL cover a simultaneous push_valid and pop2_req in IDLE with 2 entries -> pop executes, push is dropped, count=0.
REQ-039 SHALL cover reset during POP1 -> count=0, no pop_valid; also mode toggled while non-empty -> order unchanged.
